// File: rtl/apb_master_ctrl_pkg.sv
// Shared types and constants for the APB master controller slice.
package apb_master_ctrl_pkg;

    localparam int DEV_W      = 4;
    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        RESP   = 2'd3
    } apb_state_t;

endpackage

// File: rtl/apb_master_ctrl_if.sv
// APB bus bundle between the master controller and its slaves.
interface apb_master_ctrl_if
    import apb_master_ctrl_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF
);
    logic [NUM_SLAVES-1:0]        psel;
    logic                         penable;
    logic                         pwrite;
    logic [ADDR_W-1:0]            paddr;
    logic [DATA_W-1:0]            pwdata;
    logic [NUM_SLAVES*DATA_W-1:0] prdata;
    logic [NUM_SLAVES-1:0]        pready;
    logic [NUM_SLAVES-1:0]        pslverr;

    modport master (
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_master_ctrl_addr_decoder.sv
// Device number to one-hot slave select; IDs at or above NUM_SLAVES are unmapped.
module apb_master_ctrl_addr_decoder
    import apb_master_ctrl_pkg::*;
#(
    parameter int NUM_SLAVES = 4
) (
    input  logic [DEV_W-1:0]      device,
    output logic [NUM_SLAVES-1:0] sel,
    output logic                  mapped
);

    // One-hot decode; at most one bit can match a given device number.
    always_comb begin
        sel    = '0;
        mapped = 1'b0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (int'(device) == i) begin
                sel[i] = 1'b1;
                mapped = 1'b1;
            end
        end
    end

endmodule

// File: rtl/apb_master_ctrl.sv
// APB master controller: accepts one CPU request at a time and runs it on the APB bus.
//
//   state  | meaning
//   IDLE   | ready for a request; bus idle, address/data hold last values
//   SETUP  | psel asserted, penable low (one cycle)
//   ACCESS | psel + penable, waiting for pready of the selected slave or timeout
//   RESP   | rsp_valid strobe, bus released (one cycle)
//
// All outputs are registered from the next-state decode, so the bus phase seen on
// the pins matches the state register.
module apb_master_ctrl
    import apb_master_ctrl_pkg::*;
#(
    parameter int NUM_SLAVES = 4,
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int TIMEOUT    = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [DEV_W-1:0]   req_device,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [DATA_W-1:0]  req_wdata,
    input  logic               req_write,
    output logic               rsp_valid,
    output logic [DATA_W-1:0]  rsp_rdata,
    output logic               rsp_err,
    apb_master_ctrl_if.master  bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    apb_state_t state_q, state_d;

    logic [NUM_SLAVES-1:0] sel_q, sel_d;
    logic [NUM_SLAVES-1:0] psel_q, psel_d;
    logic                  penable_q, penable_d;
    logic                  pwrite_q, pwrite_d;
    logic [ADDR_W-1:0]     paddr_q, paddr_d;
    logic [DATA_W-1:0]     pwdata_q, pwdata_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic                  req_ready_q, req_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0]     rsp_rdata_q, rsp_rdata_d;
    logic                  rsp_err_q, rsp_err_d;

    logic [NUM_SLAVES-1:0] dec_sel;
    logic                  dec_mapped;
    logic                  ready_sel;
    logic                  err_sel;
    logic [DATA_W-1:0]     rdata_sel;

    apb_master_ctrl_addr_decoder #(
        .NUM_SLAVES (NUM_SLAVES)
    ) u_addr_decoder (
        .device (req_device),
        .sel    (dec_sel),
        .mapped (dec_mapped)
    );

    // Only the latched slave's handshake bits matter; the others are masked out.
    assign ready_sel = |(bus.pready & sel_q);
    assign err_sel   = |(bus.pslverr & sel_q);

    // Read-data mux driven by the latched one-hot select.
    always_comb begin
        rdata_sel = '0;
        for (int i = 0; i < NUM_SLAVES; i++) begin
            if (sel_q[i]) rdata_sel = bus.prdata[i*DATA_W +: DATA_W];
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Next state plus next values of every registered output.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        pwrite_d    = pwrite_q;
        cnt_d       = cnt_q;
        psel_d      = '0;
        penable_d   = 1'b0;
        req_ready_d = 1'b0;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;

        case (state_q)
            IDLE: begin
                req_ready_d = 1'b1;
                if (req_valid) begin
                    req_ready_d = 1'b0;
                    sel_d       = dec_sel;
                    paddr_d     = req_addr;
                    pwdata_d    = req_wdata;
                    pwrite_d    = req_write;
                    if (dec_mapped) begin
                        state_d = SETUP;
                        psel_d  = dec_sel;
                    end else begin
                        // Unmapped device: answer with an error, never touch the bus.
                        state_d     = RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                    end
                end
            end

            SETUP: begin
                state_d   = ACCESS;
                psel_d    = sel_q;
                penable_d = 1'b1;
            end

            ACCESS: begin
                psel_d    = sel_q;
                penable_d = 1'b1;
                if (ready_sel) begin
                    state_d     = RESP;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    cnt_d       = '0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = err_sel;
                    rsp_rdata_d = (!pwrite_q && !err_sel) ? rdata_sel : '0;
                end else if (cnt_q == CNT_W'(TIMEOUT)) begin
                    state_d     = RESP;
                    psel_d      = '0;
                    penable_d   = 1'b0;
                    cnt_d       = '0;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end

            RESP: begin
                state_d     = IDLE;
                req_ready_d = 1'b1;
                cnt_d       = '0;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Output and datapath registers; reset drops the bus with no response.
    always_ff @(posedge clk) begin
        if (rst) begin
            sel_q       <= '0;
            psel_q      <= '0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            cnt_q       <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            sel_q       <= sel_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            cnt_q       <= cnt_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.psel    = psel_q;
    assign bus.penable = penable_q;
    assign bus.pwrite  = pwrite_q;
    assign bus.paddr   = paddr_q;
    assign bus.pwdata  = pwdata_q;
    assign req_ready   = req_ready_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;

endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl: directed cases plus random transactions against a
// transaction-level model of latency and response.
module tb_apb_master_ctrl;

    localparam int NS  = 4;
    localparam int AW  = 8;
    localparam int DW  = 8;
    localparam int TMO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [3:0]    req_device;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_wdata;
    logic          req_write;
    logic          rsp_valid;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;

    apb_master_ctrl_if #(.NUM_SLAVES(NS), .ADDR_W(AW), .DATA_W(DW)) bus ();

    apb_master_ctrl #(
        .NUM_SLAVES (NS),
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .TIMEOUT    (TMO)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_device (req_device),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_write  (req_write),
        .rsp_valid  (rsp_valid),
        .rsp_rdata  (rsp_rdata),
        .rsp_err    (rsp_err),
        .bus        (bus)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Slave behaviour for the current transaction: target slot, wait states, error, data.
    int            sl_dev   = 0;
    int            sl_w     = 0;
    logic          sl_err   = 1'b0;
    logic [DW-1:0] sl_rdata = '0;
    int            acc_cnt  = 0;

    // Slaves change their outputs on the falling edge; non-target slaves drive noise.
    always @(negedge clk) begin
        logic [NS-1:0]    rdy;
        logic [NS-1:0]    er;
        logic [NS*DW-1:0] rd;
        rdy = NS'($urandom);
        er  = NS'($urandom);
        for (int i = 0; i < NS; i++) rd[i*DW +: DW] = DW'($urandom);
        if (bus.penable && bus.psel != '0) begin
            rdy[sl_dev] = (acc_cnt >= sl_w);
            acc_cnt++;
        end else begin
            rdy[sl_dev] = 1'b0;
            acc_cnt = 0;
        end
        er[sl_dev]            = sl_err;
        rd[sl_dev*DW +: DW]   = sl_rdata;
        bus.pready  = rdy;
        bus.pslverr = er;
        bus.prdata  = rd;
    end

    // Transaction-level expectation: cycles from accept edge to rsp_valid, error, data.
    function automatic void model(input int dev, input bit wr, input int w, input bit e,
                                  input logic [DW-1:0] d, output int lat, output bit rerr,
                                  output logic [DW-1:0] rdat);
        if (dev >= NS) begin
            lat = 1; rerr = 1'b1; rdat = '0;
        end else if (w > TMO) begin
            lat = 3 + TMO; rerr = 1'b1; rdat = '0;
        end else begin
            lat  = 3 + w;
            rerr = e;
            rdat = (wr || e) ? '0 : d;
        end
    endfunction

    logic [DW-1:0] last_rdata = '0;

    // Runs one request; must be entered right after a falling edge.
    task automatic txn(input int dev, input logic [AW-1:0] addr, input logic [DW-1:0] wd,
                       input bit wr, input int w, input bit e, input logic [DW-1:0] d);
        int            lat;
        int            got_lat;
        int            guard;
        bit            rerr;
        bit            bus_ok;
        logic [DW-1:0] rdat;
        model(dev, wr, w, e, d, lat, rerr, rdat);
        guard = 0;
        while (!req_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        chk("ready_before", req_ready, 1'b1);
        sl_dev     = (dev < NS) ? dev : 0;
        sl_w       = w;
        sl_err     = e;
        sl_rdata   = d;
        req_device = 4'(dev);
        req_addr   = addr;
        req_wdata  = wd;
        req_write  = wr;
        req_valid  = 1'b1;
        @(posedge clk);
        got_lat = -1;
        bus_ok  = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                req_valid  = 1'b0;
                req_addr   = ~addr;
                req_wdata  = ~wd;
                req_write  = ~wr;
                req_device = 4'($urandom);
                chk("ready_busy", req_ready, 1'b0);
                if (dev < NS) chk("rdata_hold", rsp_rdata, last_rdata);
            end
            if (rsp_valid) begin
                got_lat = k;
                break;
            end
            if (dev < NS) begin
                if (bus.psel !== (NS'(1) << dev)) bus_ok = 1'b0;
                if (bus.penable !== (k >= 2)) bus_ok = 1'b0;
                if (bus.paddr !== addr || bus.pwrite !== wr || bus.pwdata !== wd) bus_ok = 1'b0;
            end else if (bus.psel !== '0 || bus.penable !== 1'b0) begin
                bus_ok = 1'b0;
            end
        end
        chk("latency", got_lat, lat);
        chk("rsp_err", rsp_err, rerr);
        chk("rsp_rdata", rsp_rdata, rdat);
        chk("bus_phase", bus_ok, 1'b1);
        chk("psel_resp", {bus.psel, bus.penable}, '0);
        @(negedge clk);
        chk("rsp_one_cycle", rsp_valid, 1'b0);
        chk("ready_after", req_ready, 1'b1);
        chk("rdata_after", rsp_rdata, rdat);
        last_rdata = rdat;
    endtask

    initial begin
        bit rsp_seen;
        rst        = 1'b1;
        req_valid  = 1'b0;
        req_device = '0;
        req_addr   = '0;
        req_wdata  = '0;
        req_write  = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", req_ready, 1'b1);
        chk("rst_rsp", {rsp_valid, rsp_err, rsp_rdata}, '0);
        chk("rst_bus", {bus.psel, bus.penable, bus.pwrite, bus.paddr, bus.pwdata}, '0);
        rst = 1'b0;

        txn(1, 8'h1F, 8'hA5, 1'b1, 0, 1'b0, 8'h77);
        txn(2, 8'h03, 8'h00, 1'b0, 3, 1'b0, 8'h5C);
        txn(0, 8'h40, 8'h11, 1'b0, 0, 1'b1, 8'h99);
        txn(3, 8'h10, 8'h22, 1'b0, 1000, 1'b0, 8'h12);
        txn(9, 8'h55, 8'h33, 1'b1, 0, 1'b0, 8'h00);
        txn(2, 8'hC3, 8'h44, 1'b0, TMO, 1'b0, 8'hE7);
        txn(1, 8'h3C, 8'h55, 1'b0, TMO + 1, 1'b0, 8'h81);

        // Reset in the middle of ACCESS: bus dropped, no response.
        sl_dev     = 3;
        sl_w       = 1000;
        sl_err     = 1'b0;
        req_device = 4'd3;
        req_addr   = 8'h66;
        req_write  = 1'b0;
        req_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_access", {bus.psel, bus.penable}, {4'b1000, 1'b1});
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk("mid_rst_bus", {bus.psel, bus.penable}, '0);
        chk("mid_rst_ready", req_ready, 1'b1);
        rsp_seen = rsp_valid;
        repeat (4) begin
            @(negedge clk);
            rsp_seen = rsp_seen | rsp_valid;
        end
        chk("mid_rst_no_rsp", rsp_seen, 1'b0);
        last_rdata = '0;
        txn(1, 8'h2A, 8'h5A, 1'b1, 1, 1'b0, 8'h00);

        for (int n = 0; n < 40; n++) begin
            int dev;
            int w;
            dev = ($urandom_range(0, 9) < 8) ? $urandom_range(0, NS - 1) : $urandom_range(NS, 15);
            w   = ($urandom_range(0, 9) < 7) ? $urandom_range(0, 4) : $urandom_range(TMO - 1, TMO + 2);
            txn(dev, AW'($urandom), DW'($urandom), 1'($urandom), w,
                ($urandom_range(0, 4) == 0), DW'($urandom));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
